// File: rtl/pointwise_conv.sv
// pointwise_conv: runtime-loadable 1x1 convolution between CNN layers.
//
// Computes OUT_UNITS signed fixed-point outputs per pixel:
//   out[o] = bias[o] + sum_i w[o][i] * in[i]
// The output units are spread over LANES dot-product lanes, so one pixel
// takes PASSES = OUT_UNITS/LANES CALC cycles. Each result is rounded half-up,
// then saturated to FIXED_BITW bits.
//
// Build option: define POINTWISE_CONV_RELU_EN to clamp negative results to
// zero after saturation. This adds no latency.
//
// Ports:
//   clock, rst                 rising-edge clock; asynchronous active-high reset
//   in_valid / in_ready        input pixel handshake
//   in_pixels                  IN_UNITS channels, channel 0 in the MSBs
//   in_vcnt / in_hcnt          pixel coordinates, carried through to the output
//   out_valid / out_ready      output vector handshake
//   out_pixels                 OUT_UNITS channels, channel 0 in the MSBs
//   out_vcnt / out_hcnt        coordinates captured with the pixel
//   wt_we / wt_addr / wt_data  weight/bias write; addr = o*(IN_UNITS+1)+i,
//                              and i == IN_UNITS selects bias[o]
//   wt_ready                   a write is honoured this cycle (IDLE only)
//   busy                       FSM is not IDLE
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. The sender holds its data stable until that edge. The block
// never latches in_valid while in_ready is 0. out_ready has no effect while
// out_valid is 0.
module pointwise_conv #(
    parameter int IN_UNITS  = 12,
    parameter int OUT_UNITS = 4,
    parameter int LANES     = 2,
    parameter int INT_BITW  = 5,
    parameter int FRAC_BITW = 8,
    parameter int W_HEIGHT  = 1080,
    parameter int W_WIDTH   = 1920,
    localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
    localparam int V_BITW     = $clog2(W_HEIGHT),
    localparam int H_BITW     = $clog2(W_WIDTH),
    localparam int ADDR_BITW  = $clog2(OUT_UNITS * (IN_UNITS + 1))
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FIXED_BITW*IN_UNITS-1:0] in_pixels,
    input  logic [V_BITW-1:0]              in_vcnt,
    input  logic [H_BITW-1:0]              in_hcnt,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [FIXED_BITW*OUT_UNITS-1:0] out_pixels,
    output logic [V_BITW-1:0]              out_vcnt,
    output logic [H_BITW-1:0]              out_hcnt,
    input  logic                           wt_we,
    input  logic [ADDR_BITW-1:0]           wt_addr,
    input  logic [FIXED_BITW-1:0]          wt_data,
    output logic                           wt_ready,
    output logic                           busy
);

    localparam int PASSES    = OUT_UNITS / LANES;
    localparam int PASS_BITW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int PROD_W    = 2 * FIXED_BITW;
    localparam int ACC_W     = PROD_W + $clog2(IN_UNITS + 1);

    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1) <<< (FRAC_BITW - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-FIXED_BITW+1){1'b0}}, {(FIXED_BITW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-FIXED_BITW+1){1'b1}}, {(FIXED_BITW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                        state_q;
    logic [PASS_BITW-1:0]          pass_q;
    logic                          out_valid_q;
    logic signed [FIXED_BITW-1:0]  pix_q   [IN_UNITS];
    logic [V_BITW-1:0]             vcnt_q;
    logic [H_BITW-1:0]             hcnt_q;
    logic signed [FIXED_BITW-1:0]  out_q   [OUT_UNITS];
    logic [V_BITW-1:0]             out_vcnt_q;
    logic [H_BITW-1:0]             out_hcnt_q;

    logic signed [FIXED_BITW-1:0]  w_q     [OUT_UNITS][IN_UNITS];
    logic signed [FIXED_BITW-1:0]  b_q     [OUT_UNITS];

    // Operands selected for each lane in the current pass
    logic signed [FIXED_BITW-1:0]  w_sel   [LANES][IN_UNITS];
    logic signed [FIXED_BITW-1:0]  b_sel   [LANES];
    logic signed [PROD_W-1:0]      prod_c  [LANES][IN_UNITS];
    logic signed [ACC_W-1:0]       acc_c   [LANES];
    logic signed [ACC_W-1:0]       shr_c   [LANES];
    logic signed [FIXED_BITW-1:0]  lane_res[LANES];

    logic in_take;

    assign wt_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign in_take   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_vcnt  = out_vcnt_q;
    assign out_hcnt  = out_hcnt_q;

    always_comb begin
        out_pixels = '0;
        for (int o = 0; o < OUT_UNITS; o++) begin
            out_pixels[FIXED_BITW*(OUT_UNITS-o)-1 -: FIXED_BITW] = out_q[o];
        end
    end

    // Lane l serves unit pass*LANES+l. The pass compare uses constant
    // indices, so this is a plain mux in front of the shared lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            b_sel[l] = '0;
            for (int i = 0; i < IN_UNITS; i++) begin
                w_sel[l][i] = '0;
            end
            for (int p = 0; p < PASSES; p++) begin
                if (pass_q == PASS_BITW'(p)) begin
                    b_sel[l] = b_q[p*LANES+l];
                    for (int i = 0; i < IN_UNITS; i++) begin
                        w_sel[l][i] = w_q[p*LANES+l][i];
                    end
                end
            end
        end
    end

    // Dot product. The bias is aligned to the product scale (2*FRAC_BITW
    // fraction bits), then the sum is rounded half-up and scaled back.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            acc_c[l] = ACC_W'(b_sel[l]) <<< FRAC_BITW;
            for (int i = 0; i < IN_UNITS; i++) begin
                prod_c[l][i] = PROD_W'(w_sel[l][i]) * PROD_W'(pix_q[i]);
                acc_c[l]     = acc_c[l] + ACC_W'(prod_c[l][i]);
            end
            shr_c[l] = (acc_c[l] + ROUND_C) >>> FRAC_BITW;
            if (shr_c[l] > SAT_MAX) begin
                lane_res[l] = {1'b0, {(FIXED_BITW-1){1'b1}}};
            end else if (shr_c[l] < SAT_MIN) begin
                lane_res[l] = {1'b1, {(FIXED_BITW-1){1'b0}}};
            end else begin
                lane_res[l] = shr_c[l][FIXED_BITW-1:0];
            end
`ifdef POINTWISE_CONV_RELU_EN
            if (lane_res[l][FIXED_BITW-1]) begin
                lane_res[l] = '0;
            end
`endif
        end
    end

    // Weight/bias store. An address that matches no entry is ignored.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < OUT_UNITS; o++) begin
                b_q[o] <= '0;
                for (int i = 0; i < IN_UNITS; i++) begin
                    w_q[o][i] <= '0;
                end
            end
        end else if (wt_we && wt_ready) begin
            for (int o = 0; o < OUT_UNITS; o++) begin
                for (int i = 0; i < IN_UNITS; i++) begin
                    if (wt_addr == ADDR_BITW'(o*(IN_UNITS+1)+i)) begin
                        w_q[o][i] <= wt_data;
                    end
                end
                if (wt_addr == ADDR_BITW'(o*(IN_UNITS+1)+IN_UNITS)) begin
                    b_q[o] <= wt_data;
                end
            end
        end
    end

    // Control FSM: capture the pixel, run PASSES lane cycles, then hold.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            out_valid_q <= 1'b0;
            vcnt_q      <= '0;
            hcnt_q      <= '0;
            out_vcnt_q  <= '0;
            out_hcnt_q  <= '0;
            for (int i = 0; i < IN_UNITS; i++) begin
                pix_q[i] <= '0;
            end
            for (int o = 0; o < OUT_UNITS; o++) begin
                out_q[o] <= '0;
            end
        end else begin
            if (in_take) begin
                for (int i = 0; i < IN_UNITS; i++) begin
                    pix_q[i] <= in_pixels[FIXED_BITW*(IN_UNITS-i)-1 -: FIXED_BITW];
                end
                vcnt_q <= in_vcnt;
                hcnt_q <= in_hcnt;
            end
            case (state_q)
                IDLE: begin
                    if (in_take) begin
                        pass_q  <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    for (int p = 0; p < PASSES; p++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (pass_q == PASS_BITW'(p)) begin
                                out_q[p*LANES+l] <= lane_res[l];
                            end
                        end
                    end
                    if (pass_q == PASS_BITW'(PASSES-1)) begin
                        pass_q      <= '0;
                        out_valid_q <= 1'b1;
                        out_vcnt_q  <= vcnt_q;
                        out_hcnt_q  <= hcnt_q;
                        state_q     <= HOLD;
                    end else begin
                        pass_q <= pass_q + PASS_BITW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pass_q      <= '0;
                        state_q     <= in_valid ? CALC : IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pointwise_conv.sv
// Bench for pointwise_conv, default parameters (12 in, 4 out, 2 lanes, Q5.8).
// The drivers change inputs 1ns after the rising edge, and all sampling is
// done on the falling edge. Every time a pixel is accepted, its expected
// output vector {pixels, vcnt, hcnt} is pushed onto exp_q. The monitor pops
// one entry for each output handshake and compares it.
module tb_pointwise_conv;

  localparam int FB    = 13;
  localparam int IN_U  = 12;
  localparam int OUT_U = 4;
  localparam int VB    = 11;
  localparam int HB    = 11;
  localparam int AB    = 6;
  localparam int EW    = FB*OUT_U + VB + HB;

  logic                 clock;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [FB*IN_U-1:0]   in_pixels;
  logic [VB-1:0]        in_vcnt;
  logic [HB-1:0]        in_hcnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [FB*OUT_U-1:0]  out_pixels;
  logic [VB-1:0]        out_vcnt;
  logic [HB-1:0]        out_hcnt;
  logic                 wt_we;
  logic [AB-1:0]        wt_addr;
  logic [FB-1:0]        wt_data;
  logic                 wt_ready;
  logic                 busy;

  pointwise_conv dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels),
    .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .wt_ready(wt_ready), .busy(busy)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_vec: unexpected output %0h at %0t", out_pixels, $time);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_vec", {out_pixels, out_vcnt, out_hcnt}, e);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [FB*IN_U-1:0] mk_in(input logic [FB-1:0] c0, c1, c2, c3, rest);
    return {c0, c1, c2, c3, {8{rest}}};
  endfunction

  function automatic logic [EW-1:0] mk_exp(input logic [FB-1:0] o0, o1, o2, o3,
                                           input int v, input int h);
    return {o0, o1, o2, o3, VB'(v), HB'(h)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wt_write(input int addr, input logic [FB-1:0] data);
    bit ok;
    ok = 1'b0;
    wt_we   = 1'b1;
    wt_addr = AB'(addr);
    wt_data = data;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      ok = wt_ready;
      tick();
    end
    wt_we = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wt_write: timeout addr %0d", addr);
    end
  endtask

  // Returns 1ns after the accepting edge, with in_valid lowered
  task automatic send(input logic [FB*IN_U-1:0] pix, input int v, input int h,
                      input logic [EW-1:0] exp_v, input bit push);
    bit ok;
    ok = 1'b0;
    in_valid  = 1'b1;
    in_pixels = pix;
    in_vcnt   = VB'(v);
    in_hcnt   = HB'(h);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      ok = in_ready;
      if (ok && push) exp_q.push_back(exp_v);
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send: in_ready timeout");
    end
  endtask

  // Counts edges from the accepting edge until out_valid rises
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
  endtask

  logic [FB-1:0] sat_neg;
  logic [EW-1:0] exp_a;
  logic [EW-1:0] exp_b;
  int lat;

  // ---------------- stimulus ----------------
  initial begin
`ifdef POINTWISE_CONV_RELU_EN
    sat_neg = 13'h0000;
`else
    sat_neg = 13'h1000;
`endif
    rst = 1'b1;
    in_valid = 1'b0; in_pixels = '0; in_vcnt = '0; in_hcnt = '0;
    out_ready = 1'b1; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    repeat (2) tick();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_pixels", 128'(out_pixels), 128'(0));
    check("rst_out_vcnt", 128'(out_vcnt), 128'(0));
    check("rst_out_hcnt", 128'(out_hcnt), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_wt_ready", 128'(wt_ready), 128'(1));
    rst = 1'b0;
    tick();

    // Identity weights
    for (int o = 0; o < OUT_U; o++) wt_write(o*13 + o, 13'h0100);
    send(mk_in(13'h0100, 13'h1F00, 13'h0080, 13'h0000, 13'h0555), 5, 7,
         mk_exp(13'h0100, 13'h1F00, 13'h0080, 13'h0000, 5, 7), 1'b1);
    wait_valid(lat);
    check("latency_identity", 128'(lat), 128'(2));
    drain();

    // Bias only, then one-LSB round-up
    for (int o = 0; o < OUT_U; o++) wt_write(o*13 + o, 13'h0000);
    wt_write(25, 13'h0180);
    send(mk_in(13'h0123, 13'h0456, 13'h0789, 13'h0ABC, 13'h0321), 10, 20,
         mk_exp(13'h0000, 13'h0180, 13'h0000, 13'h0000, 10, 20), 1'b1);
    drain();
    wt_write(0, 13'h0001);
    send(mk_in(13'h0080, 13'h0FFF, 13'h1000, 13'h0001, 13'h0777), 11, 21,
         mk_exp(13'h0001, 13'h0180, 13'h0000, 13'h0000, 11, 21), 1'b1);
    drain();

    // Saturation in both directions
    for (int i = 0; i < IN_U; i++) wt_write(i, 13'h0F00);
    send({IN_U{13'h0F00}}, 12, 22, mk_exp(13'h0FFF, 13'h0180, 13'h0000, 13'h0000, 12, 22), 1'b1);
    send({IN_U{13'h1100}}, 13, 23, mk_exp(sat_neg, 13'h0180, 13'h0000, 13'h0000, 13, 23), 1'b1);
    drain();

    // Backpressure: the output must hold steady and the pending input must wait
    out_ready = 1'b0;
    exp_a = mk_exp(13'h0FFF, 13'h0180, 13'h0000, 13'h0000, 100, 200);
    exp_b = mk_exp(sat_neg, 13'h0180, 13'h0000, 13'h0000, 101, 201);
    send({IN_U{13'h0F00}}, 100, 200, exp_a, 1'b1);
    wait_valid(lat);
    check("latency_bp", 128'(lat), 128'(2));
    in_valid = 1'b1; in_pixels = {IN_U{13'h1100}}; in_vcnt = 11'd101; in_hcnt = 11'd201;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      check("bp_hold_vec", {out_pixels, out_vcnt, out_hcnt}, 128'(exp_a));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    exp_q.push_back(exp_b);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("latency_b2b", 128'(lat), 128'(2));
    drain();

    // Identity again. The write issued while busy and the out-of-range writes must be dropped.
    for (int i = 1; i < IN_U; i++) wt_write(i, 13'h0000);
    wt_write(0, 13'h0100);
    wt_write(25, 13'h0000);
    for (int o = 1; o < OUT_U; o++) wt_write(o*13 + o, 13'h0100);
    wt_write(52, 13'h0F00);
    wt_write(63, 13'h0F00);
    send(mk_in(13'h0200, 13'h0300, 13'h1E00, 13'h0040, 13'h0F00), 30, 40,
         mk_exp(13'h0200, 13'h0300, 13'h1E00, 13'h0040, 30, 40), 1'b1);
    wt_we = 1'b1; wt_addr = 6'd0; wt_data = 13'h0F00;
    @(negedge clock);
    check("busy_calc", 128'(busy), 128'(1));
    check("wt_ready_busy", 128'(wt_ready), 128'(0));
    tick();
    tick();
    wt_we = 1'b0;
    drain();
    send(mk_in(13'h0011, 13'h1FFF, 13'h0100, 13'h1000, 13'h0AAA), 31, 41,
         mk_exp(13'h0011, 13'h1FFF, 13'h0100, 13'h1000, 31, 41), 1'b1);
    drain();

    // Asynchronous reset during CALC: the pixel produces no output
    send(mk_in(13'h0100, 13'h0100, 13'h0100, 13'h0100, 13'h0100), 40, 50, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_out_pixels", 128'(out_pixels), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    send(mk_in(13'h0100, 13'h0100, 13'h0100, 13'h0100, 13'h0100), 50, 60,
         mk_exp(13'h0000, 13'h0000, 13'h0000, 13'h0000, 50, 60), 1'b1);
    drain();
    repeat (5) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d outputs missing", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
